// File: rtl/bcsa_arb.sv
// bcsa_arb: round-robin arbiter in front of one shared approximate 16-bit
// block carry-select adder built from two 8-bit blocks. The upper block
// speculates its carry-in from a single bit pair. When that guess is wrong
// the miss is flagged and counted.
// Optional feature macro: BCSA_ARB_CORRECT_EN. When it is defined, a FIX
// cycle adds the lost 0x100 back so rsp_sum is always exact. When it is
// undefined, the approximate sum is returned with rsp_err set.
module bcsa_arb #(
  parameter int NREQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [16:0]          rsp_sum,
  output logic [1:0]           rsp_id,
  output logic                 rsp_err,
  output logic [15:0]          err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  id_q, id_d;
  logic [16:0] sum_q, sum_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic [NREQ-1:0] grant;
  logic            win_found;
  logic [1:0]      win_idx;
  logic [1:0]      cand;

  logic [8:0]  lo_sum;
  logic [8:0]  hi_sum;
  logic        c_true;
  logic        c_spec;
  logic        g7;
  logic        miss;

  // Unpack the per-requester operand slices.
  logic [15:0] op_a [NREQ];
  logic [15:0] op_b [NREQ];
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign op_a[gi] = req_a[16*gi +: 16];
    assign op_b[gi] = req_b[16*gi +: 16];
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr_q + k[1:0];
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Split adder. The upper block guesses its carry-in from bit 7 alone.
  // The guess is trusted when bit 7 generates, or when bit 8 cannot
  // propagate. Otherwise the true low-block carry is used.
  always_comb begin
    lo_sum = {1'b0, a_q[7:0]} + {1'b0, b_q[7:0]};
    c_true = lo_sum[8];
    g7     = a_q[7] & b_q[7];
    c_spec = (g7 | (~a_q[8] & ~b_q[8])) ? g7 : c_true;
    hi_sum = {1'b0, a_q[15:8]} + {1'b0, b_q[15:8]} + {8'd0, c_spec};
    miss   = (c_spec != c_true);
  end

  // Next-state and datapath update for the IDLE/ADD/FIX/RESP sequence.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    sum_d   = sum_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant[win_idx] = 1'b1;
          ptr_d          = win_idx;
          a_d            = op_a[win_idx];
          b_d            = op_b[win_idx];
          id_d           = win_idx;
          state_d        = ADD;
        end
      end
      ADD: begin
        sum_d = {hi_sum, lo_sum[7:0]};
        err_d = miss;
        if (miss && (cnt_q != 16'hFFFF)) begin
          cnt_d = cnt_q + 16'd1;
        end
`ifdef BCSA_ARB_CORRECT_EN
        state_d = miss ? FIX : RESP;
`else
        state_d = RESP;
`endif
      end
`ifdef BCSA_ARB_CORRECT_EN
      FIX: begin
        // A miss always loses exactly one carry into bit 8.
        sum_d   = sum_q + 17'h00100;
        state_d = RESP;
      end
`endif
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The grant is combinational, so it is masked while reset is asserted.
  assign req_ready = grant & {NREQ{rst_n}};
  assign rsp_valid = (state_q == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: doc/bcsa_arb.md
BCSA_ARB -- requirements
Module: bcsa_arb

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one approximate 16-bit block carry-select adder (8-bit blocks); fixed at 4 in this revision.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  4  per-requester operation request.
REQ-005 req_a  input  64  packed operand A, requester i at bits [16i+15:16i].
REQ-006 req_b  input  64  packed operand B, same packing.
REQ-007 req_ready  output  4  one-hot grant; the handshake completes when req_valid[i] and req_ready[i] are both high.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_sum  output  17  sum, carry-out at bit 16.
REQ-011 rsp_id  output  2  index of the requester that owns the result.
REQ-012 rsp_err  output  1  carry speculation was wrong for this operation.
REQ-013 err_cnt  output  16  saturating count of speculation misses since reset.

Function
REQ-014 FSM states: IDLE, ADD, FIX, RESP; exactly one state active.
REQ-015 IDLE: req_ready is high only for the round-robin winner, and only when any req_valid is high; all other cycles have req_ready=0.
REQ-016 Round-robin: priority starts at ptr+1 mod 4; ptr updates to the granted index on each grant.
REQ-017 On grant, capture operands and the id, then go to ADD.
REQ-018 ADD: p=a^b, g=a&b, c_true = carry out of a[7:0]+b[7:0].
REQ-019 ADD: c_spec = g[7] when (g[7] or (a[8]==0 and b[8]==0)), else c_true.
REQ-020 ADD: sum_r[7:0] = low 8 bits of a[7:0]+b[7:0]; sum_r[16:8] = a[15:8]+b[15:8]+c_spec (9 bits).
REQ-021 ADD: err_r = (c_spec != c_true); miss is only possible as c_spec=0, c_true=1; sum_r then under-reads by exactly 256.
REQ-022 ADD: on a miss, err_cnt increments, saturating at 0xFFFF.
REQ-023 ADD next state: FIX if err_r and correction is compiled in (REQ-030), else RESP.
REQ-024 FIX: sum_r <= sum_r + 0x100, modulo 2^17, then go to RESP.
REQ-025 RESP: rsp_valid=1, and rsp_sum, rsp_id, rsp_err hold stable until rsp_ready=1.
REQ-026 RESP: on the response handshake go to IDLE; no new grant occurs in the same cycle.
REQ-027 Latency from grant cycle T: rsp_valid rises at T+2 without correction, and at T+3 with a FIX cycle; throughput is at most 1 operation per 3 cycles.
REQ-028 Requests that are not granted are held by the requester; the block stores no request state outside IDLE.

Reset
REQ-029 rst_n low: state=IDLE, ptr=3 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_err=0, err_cnt=0; this applies immediately, including mid-operation, and any in-flight operation is discarded.

Configuration
REQ-030 Macro BCSA_ARB_CORRECT_EN, when defined: the FIX state exists; rsp_sum is always the exact sum; rsp_err=1 marks a corrected operation.
REQ-031 Macro BCSA_ARB_CORRECT_EN, when undefined: the FIX state is never entered; rsp_sum is the approximate sum; rsp_err=1 marks a result that is low by 256; err_cnt counts identically in both builds.

Verification
REQ-032 Requester 0 sends a=0x1234, b=0x0101 -> rsp_sum=0x01335, rsp_err=0, rsp_id=0, rsp_valid at T+2.
REQ-033 Requester 2 sends a=0x00FF, b=0x0001 -> with the macro: rsp_sum=0x00100, rsp_err=1, at T+3; without the macro: rsp_sum=0x00000, rsp_err=1, at T+2; in both builds err_cnt=1.
REQ-034 a=0xFF80, b=0x0080 (g[7]=1) -> rsp_sum=0x10000, rsp_err=0.
REQ-035 All 4 req_valid held high, rsp_ready=1 -> grants go 0,1,2,3,0 in order, with exactly one req_ready high per grant.
REQ-036 rsp_ready=0 for 5 cycles in RESP -> rsp_valid and outputs stay stable and no grant occurs; assert rst_n low in FIX -> all outputs reach their reset values and the next grant goes to requester 0.
